// File: rtl/bcd_serial_to_bin.sv
// bcd_serial_to_bin: folds a stream of BCD digits (MSD first, one per
// handshake) into an unsigned binary value, acc = acc*10 + digit, and
// presents each completed frame on a held output handshake. Digits > 9
// are flagged and folded as 0; digits beyond NDIG are flagged and dropped.
module bcd_serial_to_bin #(
    parameter int NDIG  = 4,
    parameter int OUT_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_digit,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_value,
    output logic [3:0]       out_count,
    output logic             out_err,
    output logic             out_ovf
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam logic [3:0] NDIG_C = 4'(NDIG);

    state_t           state_q, state_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [3:0]       count_q, count_d;
    logic             err_q, err_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_value_q, out_value_d;
    logic [3:0]       out_count_q, out_count_d;
    logic             out_err_q, out_err_d;
    logic             out_ovf_q, out_ovf_d;

    logic             accept;
    logic             digit_bad;
    logic [3:0]       digit_eff;
    logic [OUT_W-1:0] acc_mac;

    assign in_ready  = (state_q == COLLECT);
    assign accept    = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign out_value = out_value_q;
    assign out_count = out_count_q;
    assign out_err   = out_err_q;
    assign out_ovf   = out_ovf_q;

    // Digit sanitising and the multiply-by-ten accumulate (x*8 + x*2 + d).
    always_comb begin
        digit_bad = (in_digit > 4'd9);
        digit_eff = digit_bad ? 4'd0 : in_digit;
        acc_mac   = (acc_q << 3) + (acc_q << 1) + OUT_W'(digit_eff);
    end

    // Next-state and datapath update: fold digits in COLLECT, hold the result in HOLD.
    always_comb begin
        logic [OUT_W-1:0] acc_n;
        logic [3:0]       count_n;
        logic             err_n;
        logic             ovf_n;

        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        err_d       = err_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_value_d = out_value_q;
        out_count_d = out_count_q;
        out_err_d   = out_err_q;
        out_ovf_d   = out_ovf_q;
        acc_n       = acc_q;
        count_n     = count_q;
        err_n       = err_q;
        ovf_n       = ovf_q;

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    err_n = err_q | digit_bad;
                    if (count_q < NDIG_C) begin
                        acc_n   = acc_mac;
                        count_n = count_q + 4'd1;
                    end else begin
                        // Frame already full: drop the digit, remember the overflow.
                        ovf_n = 1'b1;
                    end
                    acc_d   = acc_n;
                    count_d = count_n;
                    err_d   = err_n;
                    ovf_d   = ovf_n;
                    if (in_last) begin
                        // Result includes the effect of this final digit.
                        state_d     = HOLD;
                        out_valid_d = 1'b1;
                        out_value_d = acc_n;
                        out_count_d = count_n;
                        out_err_d   = err_n;
                        out_ovf_d   = ovf_n;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d     = COLLECT;
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    count_d     = 4'd0;
                    err_d       = 1'b0;
                    ovf_d       = 1'b0;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // State and data registers, all cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            acc_q       <= '0;
            count_q     <= 4'd0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_value_q <= '0;
            out_count_q <= 4'd0;
            out_err_q   <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_value_q <= out_value_d;
            out_count_q <= out_count_d;
            out_err_q   <= out_err_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_bcd_serial_to_bin.sv
// Directed bench for bcd_serial_to_bin with an expected-frame scoreboard.
module tb_bcd_serial_to_bin;

    localparam int NDIG  = 4;
    localparam int OUT_W = 14;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_digit;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_value;
    logic [3:0]       out_count;
    logic             out_err;
    logic             out_ovf;

    typedef struct {
        logic [OUT_W-1:0] value;
        logic [3:0]       count;
        logic             err;
        logic             ovf;
    } frame_t;

    frame_t sb[$];
    int     n_checks;
    int     n_fail;
    logic   accepted;
    int     bubbles;

    bcd_serial_to_bin #(.NDIG(NDIG), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_digit  (in_digit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_count (out_count),
        .out_err   (out_err),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        n_checks++;
        n_fail++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    // One cycle: sample at negedge (scoreboard pop on output handshake), then
    // advance to just after the next rising edge.
    task automatic tick();
        frame_t f;
        @(negedge clk);
        accepted = in_valid & in_ready;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                fail_now("unexpected_frame");
            end else begin
                f = sb.pop_front();
                chk("out_value", 32'(out_value), 32'(f.value));
                chk("out_count", 32'(out_count), 32'(f.count));
                chk("out_err",   32'(out_err),   32'(f.err));
                chk("out_ovf",   32'(out_ovf),   32'(f.ovf));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int v, input int c, input logic e, input logic o);
        frame_t f;
        f.value = OUT_W'(v);
        f.count = 4'(c);
        f.err   = e;
        f.ovf   = o;
        sb.push_back(f);
    endtask

    // Present one digit until accepted; returns the number of stalled cycles.
    task automatic send(input logic [3:0] d, input logic last, output int stalls);
        int n;
        in_valid = 1'b1;
        in_digit = d;
        in_last  = last;
        n = 0;
        accepted = 1'b0;
        while (!accepted && n < 40) begin
            tick();
            if (!accepted) n++;
        end
        if (!accepted) fail_now("send_timeout");
        in_valid = 1'b0;
        in_last  = 1'b0;
        stalls   = n;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        if (sb.size() != 0) fail_now("drain_timeout");
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_digit  = 4'd0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        accepted  = 1'b0;
        bubbles   = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_value", 32'(out_value), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_out_err",   32'(out_err),   32'd0);
        chk("rst_out_ovf",   32'(out_ovf),   32'd0);

        // Frame 1,2,3,4 -> 1234
        push(1234, 4, 1'b0, 1'b0);
        send(4'd1, 1'b0, bubbles);
        send(4'd2, 1'b0, bubbles);
        send(4'd3, 1'b0, bubbles);
        send(4'd4, 1'b1, bubbles);
        chk("t1_out_valid_next", 32'(out_valid), 32'd1);
        chk("t1_in_ready_hold",  32'(in_ready),  32'd0);
        chk("t1_value_early",    32'(out_value), 32'd1234);
        out_ready = 1'b1;
        tick();
        chk("t1_in_ready_back", 32'(in_ready),  32'd1);
        chk("t1_valid_drop",    32'(out_valid), 32'd0);

        // Single-digit 7 then 9999 back-to-back, out_ready tied high
        push(7, 1, 1'b0, 1'b0);
        push(9999, 4, 1'b0, 1'b0);
        send(4'd7, 1'b1, bubbles);
        send(4'd9, 1'b0, bubbles);
        chk("t2_bubble", 32'(bubbles), 32'd1);
        send(4'd9, 1'b0, bubbles);
        chk("t2_no_stall", 32'(bubbles), 32'd0);
        send(4'd9, 1'b0, bubbles);
        send(4'd9, 1'b1, bubbles);
        drain();

        // Non-BCD digit folds as 0 and sets err
        push(503, 3, 1'b1, 1'b0);
        send(4'd5, 1'b0, bubbles);
        send(4'hB, 1'b0, bubbles);
        send(4'd3, 1'b1, bubbles);
        drain();

        // Five digits with NDIG=4: fifth dropped, ovf set
        push(1234, 4, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) send(4'(i), (i == 5), bubbles);
        drain();

        // Backpressure: frame 42 held while digit 6 waits
        out_ready = 1'b0;
        push(42, 2, 1'b0, 1'b0);
        send(4'd4, 1'b0, bubbles);
        send(4'd2, 1'b1, bubbles);
        in_valid = 1'b1;
        in_digit = 4'd6;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_not_accepted", 32'(accepted),  32'd0);
            chk("bp_out_valid",    32'(out_valid), 32'd1);
            chk("bp_out_value",    32'(out_value), 32'd42);
            chk("bp_in_ready",     32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        push(6, 1, 1'b0, 1'b0);
        tick();
        chk("bp_handshake_no_accept", 32'(accepted), 32'd0);
        tick();
        chk("bp_digit6_accepted", 32'(accepted), 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        drain();

        // Asynchronous reset mid-frame discards 8,8
        send(4'd8, 1'b0, bubbles);
        send(4'd8, 1'b0, bubbles);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready",  32'(in_ready),  32'd1);
        rst_n = 1'b1;
        push(3, 1, 1'b0, 1'b0);
        send(4'd3, 1'b1, bubbles);
        drain();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
